// File: rtl/stream_pkg.sv
// Shared widths for the byte-stream pipeline: lane width, lanes per word and derived sizes.
package stream_pkg;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned RATIO  = 4;
    localparam int unsigned OUT_W  = BYTE_W * RATIO;
    localparam int unsigned CNT_W  = $clog2(RATIO);
endpackage

// File: rtl/byte_word_packer_if.sv
// Handshake bundle of the packer: byte stream in, packed word stream out.
interface byte_word_packer_if #(
    parameter int unsigned BYTE_W = stream_pkg::BYTE_W,
    parameter int unsigned RATIO  = stream_pkg::RATIO
);
    localparam int unsigned OUT_W = BYTE_W * RATIO;

    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [RATIO-1:0]  out_keep;
    logic              out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/pack_accum.sv
// Lane accumulator: gathers accepted bytes into a word and flags the byte that completes it.
module pack_accum #(
    parameter int unsigned BYTE_W = stream_pkg::BYTE_W,
    parameter int unsigned RATIO  = stream_pkg::RATIO
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      accept,
    input  logic [BYTE_W-1:0]         data,
    input  logic                      last,
    output logic                      done_c,
    output logic [BYTE_W*RATIO-1:0]   word_c,
    output logic [RATIO-1:0]          keep_c
);
    localparam int unsigned OUT_W = BYTE_W * RATIO;
    localparam int unsigned CNT_W = $clog2(RATIO);

    logic [OUT_W-1:0] acc;
    logic [RATIO-1:0] keep_acc;
    logic [CNT_W-1:0] cnt;

    // Word as it would look with the current byte merged into lane cnt.
    always_comb begin
        word_c = acc;
        keep_c = keep_acc;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (CNT_W'(i) == cnt) begin
                word_c[i*BYTE_W +: BYTE_W] = data;
                keep_c[i]                  = 1'b1;
            end
        end
    end

    assign done_c = accept && ((cnt == CNT_W'(RATIO - 1)) || last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            keep_acc <= '0;
            cnt      <= '0;
        end else if (done_c) begin
            acc      <= '0;
            keep_acc <= '0;
            cnt      <= '0;
        end else if (accept) begin
            acc      <= word_c;
            keep_acc <= keep_c;
            cnt      <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/byte_word_packer.sv
// Packs RATIO consecutive bytes (or fewer, closed by in_last) into one word behind a single output slot.
module byte_word_packer #(
    parameter int unsigned BYTE_W = stream_pkg::BYTE_W,
    parameter int unsigned RATIO  = stream_pkg::RATIO
) (
    input  logic               clk,
    input  logic               rst_n,
    byte_word_packer_if.slave  bus
);
    localparam int unsigned OUT_W = BYTE_W * RATIO;

    logic             accept;
    logic             done_c;
    logic [OUT_W-1:0] word_c;
    logic [RATIO-1:0] keep_c;

    logic             slot_valid;
    logic [OUT_W-1:0] slot_data;
    logic [RATIO-1:0] slot_keep;
    logic             slot_last;
    logic             in_ready;

    // Slot can take a new word when empty or being drained this cycle.
    assign in_ready = !slot_valid || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    pack_accum #(
        .BYTE_W (BYTE_W),
        .RATIO  (RATIO)
    ) u_pack_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
        .data   (bus.in_data),
        .last   (bus.in_last),
        .done_c (done_c),
        .word_c (word_c),
        .keep_c (keep_c)
    );

    // Reload on completion wins over drain, so back-to-back words leave no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= 1'b0;
            slot_data  <= '0;
            slot_keep  <= '0;
            slot_last  <= 1'b0;
        end else if (done_c) begin
            slot_valid <= 1'b1;
            slot_data  <= word_c;
            slot_keep  <= keep_c;
            slot_last  <= bus.in_last;
        end else if (bus.out_ready) begin
            slot_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = slot_valid;
    assign bus.out_data  = slot_data;
    assign bus.out_keep  = slot_keep;
    assign bus.out_last  = slot_last;
endmodule

// File: tb/tb_byte_word_packer.sv
// Randomised and directed bench for byte_word_packer against a queue-based packing model.
module tb_byte_word_packer;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned RATIO  = 4;
    localparam int unsigned OUT_W  = BYTE_W * RATIO;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [RATIO-1:0] keep;
        logic             last;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    byte_word_packer_if #(.BYTE_W(BYTE_W), .RATIO(RATIO)) bus ();

    byte_word_packer #(.BYTE_W(BYTE_W), .RATIO(RATIO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    word_t            exp_q[$];
    logic [7:0]       part_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    logic             s_valid, s_ready, s_last, accepted;
    logic [OUT_W-1:0] s_data;
    logic [RATIO-1:0] s_keep;
    logic             hold_prev = 1'b0;
    logic [OUT_W-1:0] p_data;
    logic [RATIO-1:0] p_keep;
    logic             p_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Model: collect accepted bytes, emit a word on in_last or after RATIO bytes.
    task automatic model_accept(input logic [7:0] d, input logic l);
        word_t w;
        part_q.push_back(d);
        if (l || part_q.size() == RATIO) begin
            w.data = '0;
            w.keep = '0;
            foreach (part_q[i]) begin
                w.data[i*8 +: 8] = part_q[i];
                w.keep[i]        = 1'b1;
            end
            w.last = l;
            exp_q.push_back(w);
            part_q.delete();
        end
    endtask

    // One cycle: drive at negedge, sample 1ns later, score what the next posedge will do.
    task automatic step(input logic iv, input logic [7:0] d, input logic il, input logic ordy);
        word_t w;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_last   = il;
        bus.out_ready = ordy;
        #1;
        s_valid = bus.out_valid;
        s_ready = bus.in_ready;
        s_data  = bus.out_data;
        s_keep  = bus.out_keep;
        s_last  = bus.out_last;
        check("in_ready_rule", 32'(s_ready), 32'(!s_valid || ordy));
        if (hold_prev) begin
            check("hold_valid", 32'(s_valid), 32'(1));
            check("hold_data",  s_data, p_data);
            check("hold_keep",  32'(s_keep), 32'(p_keep));
            check("hold_last",  32'(s_last), 32'(p_last));
        end
        if (s_valid && ordy) begin
            check("word_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("sb_data", s_data, w.data);
                check("sb_keep", 32'(s_keep), 32'(w.keep));
                check("sb_last", 32'(s_last), 32'(w.last));
            end
        end
        accepted = iv && s_ready;
        if (accepted) model_accept(d, il);
        hold_prev = s_valid && !ordy;
        p_data = s_data;
        p_keep = s_keep;
        p_last = s_last;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'(0));
        check("rst_data",  bus.out_data, 32'(0));
        check("rst_keep",  32'(bus.out_keep), 32'(0));
        check("rst_last",  32'(bus.out_last), 32'(0));
        part_q.delete();
        exp_q.delete();
        hold_prev = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        do_reset();

        // Full word, back to back
        step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
        step(0, 8'h00, 0, 1);
        check("t1_valid", 32'(s_valid), 32'(1));
        check("t1_data",  s_data, 32'h4433_2211);
        check("t1_keep",  32'(s_keep), 32'hF);
        check("t1_last",  32'(s_last), 32'(0));

        // Continuous 8 bytes, in_ready must stay high
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            step(1, b, 0, 1);
            check("t2_ready", 32'(s_ready), 32'(1));
            if (i == 5) check("t2_word0", s_data, 32'h0403_0201);
        end
        step(0, 8'h00, 0, 1);
        check("t2_word1", s_data, 32'h0807_0605);

        // Short packet then a fresh word from lane 0
        step(1, 8'hAA, 0, 1); step(1, 8'hBB, 1, 1);
        step(0, 8'h00, 0, 1);
        check("t3_data", s_data, 32'h0000_BBAA);
        check("t3_keep", 32'(s_keep), 32'h3);
        check("t3_last", 32'(s_last), 32'(1));
        step(1, 8'hC1, 0, 1); step(1, 8'hC2, 0, 1); step(1, 8'hC3, 0, 1); step(1, 8'hC4, 0, 1);
        step(0, 8'h00, 0, 1);
        check("t3_next", s_data, 32'hC4C3_C2C1);
        check("t3_next_keep", 32'(s_keep), 32'hF);

        // Backpressure: full slot held five cycles
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i);
            step(1, b, 0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 8'hEE, 1, 0);
            check("t4_ready_low", 32'(s_ready), 32'(0));
            check("t4_data", s_data, 32'h0403_0201);
        end
        step(0, 8'h00, 0, 1);
        check("t4_ready_high", 32'(s_ready), 32'(1));
        step(0, 8'h00, 0, 1);
        check("t4_drained", 32'(s_valid), 32'(0));

        // Completing byte on the draining edge: no bubble
        step(1, 8'hA1, 0, 0); step(1, 8'hA2, 0, 0); step(1, 8'hA3, 0, 0); step(1, 8'hA4, 0, 0);
        step(1, 8'hE5, 1, 1);
        check("t5_ready", 32'(s_ready), 32'(1));
        step(0, 8'h00, 0, 0);
        check("t5_valid", 32'(s_valid), 32'(1));
        check("t5_data",  s_data, 32'h0000_00E5);
        check("t5_keep",  32'(s_keep), 32'h1);
        check("t5_last",  32'(s_last), 32'(1));
        step(0, 8'h00, 0, 1);

        // Reset mid-word discards the partial word
        step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1);
        do_reset();
        step(1, 8'h5A, 0, 1); step(1, 8'h6B, 0, 1); step(1, 8'h7C, 0, 1); step(1, 8'h8D, 0, 1);
        step(0, 8'h00, 0, 1);
        check("t6_data", s_data, 32'h8D7C_6B5A);
        check("t6_keep", 32'(s_keep), 32'hF);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, 8'($urandom), ($urandom % 5) == 0, ($urandom % 3) != 0);
        end

        // Flush any partial word, then drain the slot
        for (int i = 0; i < 50; i++) begin
            step(1, 8'hFF, 1, 1);
            if (accepted) break;
        end
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1);
        check("final_words_left", 32'(exp_q.size()), 32'(0));
        check("final_bytes_left", 32'(part_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
